uart_rx: RTL and testbench

//  Serial receive stage of the UART. It consumes the line driven by uart_tx (or the external
//  pin), oversampled by ticks from uart_bdgen, and recovers frames. Frames have: start bit,
//  5..8 data bits LSB-first, optional parity, and 1..2 stop bits. Each recovered word goes

---
 rtl/uart_rx.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Purpose : Oversampled UART receiver with 2-of-3 majority bit voting and a
//           single-entry valid/ready holding register carrying error flags.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int OVS      = 16,
    parameter int DATA_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pls_rx,
    input  logic                uart_rxd,
    input  logic                parity_en,
    input  logic                parity_even,
    input  logic [3:0]          data_len,
    input  logic [1:0]          stop_len,
    output logic [DATA_MAX-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun,
    output logic                rx_busy
);
    localparam int c_TW = $clog2(OVS);
    localparam int c_IW = $clog2(DATA_MAX);
    localparam logic [c_TW-1:0] c_TICK_S0  = c_TW'(OVS / 2 - 1);
    localparam logic [c_TW-1:0] c_TICK_S1  = c_TW'(OVS / 2);
    localparam logic [c_TW-1:0] c_TICK_DEC = c_TW'(OVS / 2 + 1);
    localparam logic [c_TW-1:0] c_TICK_END = c_TW'(OVS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [c_TW-1:0]     tick_q, tick_d;
    logic [3:0]          bit_q, bit_d;
    logic [1:0]          samp_q, samp_d;
    logic [DATA_MAX-1:0] data_q, data_d;
    logic [3:0]          len_q, len_d;
    logic                stop2_q, stop2_d;
    logic                par_en_q, par_en_d;
    logic                par_even_q, par_even_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                armed_q, armed_d;
    logic                rxd_meta_q, rxd_meta_d;
    logic                rxd_sync_q, rxd_sync_d;
    logic [DATA_MAX-1:0] rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                parity_err_q, parity_err_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q, overrun_d;
    logic                rx_busy_q, rx_busy_d;

    logic w_maj, w_dec, w_end, w_done, w_ferr_next;

    assign w_maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_sync_q) | (samp_q[1] & rxd_sync_q);
    assign w_dec = pls_rx && (tick_q == c_TICK_DEC);
    assign w_end = pls_rx && (tick_q == c_TICK_END);
    assign w_ferr_next = ferr_q | ~w_maj;

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        samp_d       = samp_q;
        data_d       = data_q;
        len_d        = len_q;
        stop2_d      = stop2_q;
        par_en_d     = par_en_q;
        par_even_d   = par_even_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        armed_d      = armed_q;
        rxd_meta_d   = uart_rxd;
        rxd_sync_d   = rxd_meta_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        w_done       = 1'b0;

        if (pls_rx && state_q != S_IDLE) begin
            tick_d = (tick_q == c_TICK_END) ? '0 : tick_q + 1'b1;
            if (tick_q == c_TICK_S0) samp_d[0] = rxd_sync_q;
            if (tick_q == c_TICK_S1) samp_d[1] = rxd_sync_q;
        end

        unique case (state_q)
            S_IDLE: begin
                // Re-arm only after a high level, so a held break yields one word.
                if (rxd_sync_q) armed_d = 1'b1;
                if (pls_rx && armed_q && !rxd_sync_q) begin
                    state_d    = S_START;
                    tick_d     = '0;
                    bit_d      = 4'd0;
                    data_d     = '0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    armed_d    = 1'b0;
                    len_d      = (data_len >= 4'd5 && data_len <= 4'd8) ? data_len : 4'd8;
                    stop2_d    = (stop_len == 2'd2);
                    par_en_d   = parity_en;
                    par_even_d = parity_even;
                end
            end
            S_START: begin
                if (w_dec && w_maj) begin
                    state_d = S_IDLE;
                end else if (w_end) begin
                    state_d = S_DATA;
                    bit_d   = 4'd0;
                end
            end
            S_DATA: begin
                if (w_dec) data_d[bit_q[c_IW-1:0]] = w_maj;
                if (w_end) begin
                    if (bit_q == len_q - 4'd1) begin
                        bit_d   = 4'd0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_dec) perr_d = (^data_q) ^ w_maj ^ ~par_even_q;
                if (w_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (w_dec) begin
                    ferr_d = w_ferr_next;
                    if (bit_q == {3'b000, stop2_q}) begin
                        w_done  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (w_end) begin
                    bit_d = bit_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_done) begin
            if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                rx_data_d    = data_q;
                rx_valid_d   = 1'b1;
                parity_err_d = perr_q;
                frame_err_d  = w_ferr_next;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        rx_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tick_q       <= '0;
            bit_q        <= 4'd0;
            samp_q       <= 2'b00;
            data_q       <= '0;
            len_q        <= 4'd0;
            stop2_q      <= 1'b0;
            par_en_q     <= 1'b0;
            par_even_q   <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            armed_q      <= 1'b0;
            rxd_meta_q   <= 1'b1;
            rxd_sync_q   <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            samp_q       <= samp_d;
            data_q       <= data_d;
            len_q        <= len_d;
            stop2_q      <= stop2_d;
            par_en_q     <= par_en_d;
            par_even_q   <= par_even_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            armed_q      <= armed_d;
            rxd_meta_q   <= rxd_meta_d;
            rxd_sync_q   <= rxd_sync_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            rx_busy_q    <= rx_busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign rx_busy    = rx_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx
// Purpose : Directed and randomized frame bench for uart_rx (OVS=16, tick/5clk).
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pls_rx = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_even = 1'b0;
    logic [3:0] data_len = 4'd8;
    logic [1:0] stop_len = 2'd1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pcnt = 0;

    uart_rx #(.OVS(16), .DATA_MAX(8)) dut (
        .clk(clk), .rst(rst), .pls_rx(pls_rx), .uart_rxd(uart_rxd),
        .parity_en(parity_en), .parity_even(parity_even),
        .data_len(data_len), .stop_len(stop_len),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        pcnt   <= (pcnt == 4) ? 0 : pcnt + 1;
        pls_rx <= (pcnt == 4);
    end

    // Observed handshakes as {parity_err, frame_err, rx_data}.
    logic [9:0] got_q[$];
    int ovr_cnt = 0;
    int vhigh = 0;
    int vrise_cyc = -1;
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back({parity_err, frame_err, rx_data});
        if (overrun) ovr_cnt++;
        if (rx_valid) vhigh++;
        if (rx_valid && !prev_v) vrise_cyc = cyc;
        prev_v = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_len(input int raw);
        return (raw >= 5 && raw <= 8) ? raw : 8;
    endfunction

    function automatic int eff_stop(input int raw);
        return (raw == 2) ? 2 : 1;
    endfunction

    // Reference: what the receiver must report for a given transmitted frame.
    function automatic logic [9:0] model(input logic [7:0] d, input int len, input bit pen,
                                         input bit peven, input bit pbit, input int nstop,
                                         input bit [1:0] sz);
        logic [7:0] w;
        int         ones;
        bit         pe;
        bit         fe;
        w    = 8'(int'(d) % (1 << len));
        ones = $countones(w) + int'(pbit);
        pe   = pen && ((ones % 2) != (peven ? 0 : 1));
        fe   = sz[0] || (nstop == 2 && sz[1]);
        return {pe, fe, w};
    endfunction

    task automatic set_cfg(input int len_raw, input int stop_raw, input bit pen, input bit peven);
        data_len    = 4'(len_raw);
        stop_len    = 2'(stop_raw);
        parity_en   = pen;
        parity_even = peven;
    endtask

    // Leaves us 1 time unit after the posedge that is 3 clocks before a tick edge.
    task automatic align(output int p0);
        @(negedge clk);
        for (int k = 0; k < 10 && !pls_rx; k++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        p0 = cyc;
    endtask

    task automatic send_bits(input logic [7:0] d, input int len, input bit pen, input bit pbit,
                             input int nstop, input bit [1:0] sz, input int glitch_bit,
                             input bit scramble);
        bit q[$];
        q.push_back(1'b0);
        for (int i = 0; i < len; i++) q.push_back(d[i]);
        if (pen) q.push_back(pbit);
        for (int s = 0; s < nstop; s++) q.push_back(~sz[s]);
        for (int b = 0; b < q.size(); b++) begin
            uart_rxd = q[b];
            for (int c = 1; c <= 80; c++) begin
                @(posedge clk);
                #1;
                if (b == glitch_bit && c == 45) uart_rxd = ~q[b];
                if (b == glitch_bit && c == 49) uart_rxd = q[b];
                if (scramble && b == 1 && c == 1) begin
                    data_len    = 4'($urandom);
                    stop_len    = 2'($urandom);
                    parity_en   = 1'($urandom);
                    parity_even = 1'($urandom);
                end
            end
        end
        uart_rxd = 1'b1;
    endtask

    task automatic frame(input logic [7:0] d, input int len_raw, input int stop_raw, input bit pen,
                         input bit peven, input bit pbit, input bit [1:0] sz, input int glitch_bit,
                         input bit scramble);
        int p0;
        set_cfg(len_raw, stop_raw, pen, peven);
        align(p0);
        send_bits(d, eff_len(len_raw), pen, pbit, eff_stop(stop_raw), sz, glitch_bit, scramble);
        repeat (40) @(posedge clk);
        #1;
    endtask

    int rd = 0;
    task automatic expect_word(input string tag, input logic [9:0] exp);
        check({tag, ".count"}, got_q.size() - rd, 1);
        if (got_q.size() > rd) check({tag, ".word"}, got_q[rd], exp);
        rd = got_q.size();
    endtask

    initial begin
        int         p0;
        int         v0;
        int         o0;
        logic [7:0] d;
        int         lr;
        int         sr;
        bit         pen;
        bit         pev;
        bit         pb;
        bit [1:0]   sz;

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        check("rst.valid", rx_valid, 0);
        check("rst.data", rx_data, 0);
        check("rst.busy", rx_busy, 0);
        check("rst.overrun", overrun, 0);
        check("rst.flags", {parity_err, frame_err}, 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // 8N1 0xA5: one-cycle valid, latency about 9.5 bit times
        set_cfg(8, 1, 1'b0, 1'b0);
        v0 = vhigh;
        align(p0);
        fork
            send_bits(8'hA5, 8, 1'b0, 1'b0, 1, 2'b00, -1, 1'b0);
            begin
                repeat (200) @(posedge clk);
                #1;
                check("t1.busy_mid", rx_busy, 1);
            end
        join
        repeat (40) @(posedge clk);
        #1;
        expect_word("t1.8n1", {2'b00, 8'hA5});
        check("t1.valid_width", vhigh - v0, 1);
        check("t1.latency_window", (vrise_cyc - p0 >= 740) && (vrise_cyc - p0 <= 800), 1);

        // 8E2 with correct and wrong parity
        frame(8'h0F, 8, 2, 1'b1, 1'b1, 1'b0, 2'b00, -1, 1'b0);
        expect_word("t2.8e2_ok", {2'b00, 8'h0F});
        frame(8'h0F, 8, 2, 1'b1, 1'b1, 1'b1, 2'b00, -1, 1'b0);
        expect_word("t2.8e2_bad", {2'b10, 8'h0F});

        // 5O1, then stop bit forced low
        frame(8'h13, 5, 1, 1'b1, 1'b0, 1'b0, 2'b00, -1, 1'b0);
        expect_word("t3.5o1", {2'b00, 8'h13});
        frame(8'h13, 5, 1, 1'b1, 1'b0, 1'b0, 2'b01, -1, 1'b0);
        expect_word("t3.5o1_ferr", {2'b01, 8'h13});

        // 3-tick low glitch in idle is a false start
        uart_rxd = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        uart_rxd = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t4.false_start_busy", rx_busy, 1);
        repeat (100) @(posedge clk);
        #1;
        check("t4.false_start_idle", rx_busy, 0);
        check("t4.false_start_noword", got_q.size() - rd, 0);
        // 1-tick glitch inside data bit 2 is voted out
        frame(8'hA5, 8, 1, 1'b0, 1'b0, 1'b0, 2'b00, 3, 1'b0);
        expect_word("t4.midbit_glitch", {2'b00, 8'hA5});

        // Break: one zero word with frame error, then re-arm on high line
        set_cfg(8, 1, 1'b0, 1'b0);
        align(p0);
        uart_rxd = 1'b0;
        repeat (1600) @(posedge clk);
        #1;
        uart_rxd = 1'b1;
        repeat (160) @(posedge clk);
        #1;
        expect_word("brk.word", {2'b01, 8'h00});
        frame(8'h3C, 8, 1, 1'b0, 1'b0, 1'b0, 2'b00, -1, 1'b0);
        expect_word("brk.rearm", {2'b00, 8'h3C});

        // Overrun, then accept coinciding with completion
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        frame(8'h11, 8, 1, 1'b0, 1'b0, 1'b0, 2'b00, -1, 1'b0);
        frame(8'h22, 8, 1, 1'b0, 1'b0, 1'b0, 2'b00, -1, 1'b0);
        check("t5.overrun_once", ovr_cnt - o0, 1);
        check("t5.hold_valid", rx_valid, 1);
        check("t5.hold_data", rx_data, 8'h11);
        set_cfg(8, 1, 1'b0, 1'b0);
        align(p0);
        fork
            send_bits(8'h33, 8, 1'b0, 1'b0, 1, 2'b00, -1, 1'b0);
            begin
                // Completion edge is 53 + 80*9 clocks after p0 for 8N1.
                repeat (52 + 720) @(posedge clk);
                #1;
                rx_ready = 1'b1;
            end
        join
        repeat (40) @(posedge clk);
        #1;
        check("t5.two_words", got_q.size() - rd, 2);
        if (got_q.size() >= rd + 2) begin
            check("t5.first", got_q[rd], {2'b00, 8'h11});
            check("t5.second", got_q[rd+1], {2'b00, 8'h33});
        end
        rd = got_q.size();
        check("t5.no_new_overrun", ovr_cnt - o0, 1);

        // Reset during data bits aborts the frame
        set_cfg(8, 1, 1'b0, 1'b0);
        align(p0);
        fork
            send_bits(8'h55, 8, 1'b0, 1'b0, 1, 2'b00, -1, 1'b0);
            begin
                repeat (260) @(posedge clk);
                #1;
                check("t6.busy_before_rst", rx_busy, 1);
                rst = 1'b1;
                @(posedge clk);
                #1;
                check("t6.rst_busy", rx_busy, 0);
                check("t6.rst_valid", rx_valid, 0);
                check("t6.rst_data", rx_data, 0);
            end
        join
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("t6.no_word", got_q.size() - rd, 0);
        frame(8'h66, 8, 1, 1'b0, 1'b0, 1'b0, 2'b00, -1, 1'b0);
        expect_word("t6.after_rst", {2'b00, 8'h66});

        // Randomized frames, config scrambled after start detect
        for (int n = 0; n < 16; n++) begin
            d   = 8'($urandom);
            lr  = ($urandom % 4 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(5, 8));
            sr  = int'($urandom_range(0, 3));
            pen = 1'($urandom);
            pev = 1'($urandom);
            pb  = 1'($urandom);
            sz  = ($urandom % 4 == 0) ? 2'($urandom) : 2'b00;
            frame(d, lr, sr, pen, pev, pb, sz, -1, 1'b1);
            expect_word($sformatf("rnd%0d", n), model(d, eff_len(lr), pen, pev, pb, eff_stop(sr), sz));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
